// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | prog_loader_pkg                                                             |
// | Shared types and constants for the boot loader and its consumers.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package prog_loader_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int WORD_W    = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE = 2'b00;
    localparam err_code_t ERR_LEN  = 2'b01;
    localparam err_code_t ERR_CSUM = 2'b10;
    localparam err_code_t ERR_TMO  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | prog_loader_if                                                              |
// | Byte valid/ready stream feeding the loader.                                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = WORD_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | prog_loader_timer                                                           |
// | Idle-cycle counter; expired_o flags the TIMEOUT-th consecutive idle cycle.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module prog_loader_timer #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en_i,
    input  wire logic clr_i,
    output logic      expired_o
);

    // The count only needs to hold TIMEOUT-1; the final idle cycle fires expired_o.
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] count_q;

    assign expired_o = en_i && (count_q == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (en_i && !expired_o) begin
            count_q <= count_q + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | prog_loader                                                                 |
// | Loads a LEN/payload/CSUM framed program into CPU memory, then releases CPU. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = $clog2(MEM_DEPTH),
    parameter int DATA_W  = WORD_W,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start_i,
    prog_loader_if.slave       s_if,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    output logic               cpu_hold_o,
    output logic               cpu_run_o,
    output logic               load_err_o,
    output logic [1:0]         err_code_o
);

    localparam int                c_DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W + 1)'(1);

    state_e              state_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     cnt_q;
    logic [DATA_W-1:0]   sum_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                cpu_hold_q;
    logic                cpu_run_q;
    logic                load_err_q;
    err_code_t           err_code_q;

    logic                w_busy;
    logic                w_xfer;
    logic                w_tmo;
    logic                w_len_ok;
    logic                w_last_byte;
    logic [DATA_W-1:0]   w_sum_next;
    logic                w_err;
    err_code_t           w_err_code;

    assign w_busy      = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign w_xfer      = w_busy && s_if.in_valid;
    assign s_if.in_ready = w_busy;

    assign w_len_ok    = (s_if.in_data != '0) && (int'(s_if.in_data) <= c_DEPTH);
    assign w_last_byte = (cnt_q + c_CNT_ONE) == len_q;
    assign w_sum_next  = sum_q + s_if.in_data;

    prog_loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en_i      (w_busy && !w_xfer),
        .clr_i     (!w_busy || w_xfer),
        .expired_o (w_tmo)
    );

    // Timeout can only fire on a cycle without a transfer, so the causes are exclusive.
    always_comb begin
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        if (w_tmo) begin
            w_err      = 1'b1;
            w_err_code = ERR_TMO;
        end else if (w_xfer && (state_q == LEN) && !w_len_ok) begin
            w_err      = 1'b1;
            w_err_code = ERR_LEN;
        end else if (w_xfer && (state_q == CSUM) && (w_sum_next != '0)) begin
            w_err      = 1'b1;
            w_err_code = ERR_CSUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            cpu_run_q   <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            mem_we_q <= 1'b0;
            if (w_err) begin
                state_q    <= ERR;
                load_err_q <= 1'b1;
                err_code_q <= w_err_code;
                cpu_hold_q <= 1'b1;
                cpu_run_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, RUN, ERR: begin
                        if (start_i) begin
                            state_q    <= LEN;
                            sum_q      <= '0;
                            cnt_q      <= '0;
                            load_err_q <= 1'b0;
                            err_code_q <= ERR_NONE;
                            cpu_hold_q <= 1'b1;
                            cpu_run_q  <= 1'b0;
                        end
                    end
                    LEN: begin
                        if (w_xfer) begin
                            len_q   <= s_if.in_data[ADDR_W:0];
                            sum_q   <= s_if.in_data;
                            cnt_q   <= '0;
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (w_xfer) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= cnt_q[ADDR_W-1:0];
                            mem_wdata_q <= s_if.in_data;
                            sum_q       <= w_sum_next;
                            cnt_q       <= cnt_q + c_CNT_ONE;
                            if (w_last_byte) begin
                                state_q <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        // A failing checksum was already routed to ERR above.
                        if (w_xfer) begin
                            state_q    <= RUN;
                            cpu_hold_q <= 1'b0;
                            cpu_run_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_hold_o  = cpu_hold_q;
    assign cpu_run_o   = cpu_run_q;
    assign load_err_o  = load_err_q;
    assign err_code_o  = err_code_q;

endmodule
`default_nettype wire
